// File: rtl/async_fifo_top.sv
// Gray-pointer FIFO on a single clock with asynchronous active-low reset.
// Define PTR_SYNC_EN to pass the exchanged Gray pointers through 2-flop synchronizers.
module async_fifo_top #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [width-1:0] w_data,
    input  logic             rinc,
    output logic [width-1:0] r_data,
    output logic             full,
    output logic             empty
);
    localparam int ADDR = $clog2(depth);
    localparam logic [ADDR:0] PTR_ONE   = (ADDR + 1)'(1);
    // Inverting the top two Gray bits maps "same address, opposite lap" onto equality.
    localparam logic [ADDR:0] FULL_MASK = (ADDR + 1)'(3) << (ADDR - 1);

    logic [width-1:0] r_mem [depth];
    logic [ADDR:0]    r_wbin;
    logic [ADDR:0]    r_rbin;
    logic [ADDR:0]    r_wgray;
    logic [ADDR:0]    r_rgray;
    logic [ADDR:0]    w_wbin_nxt;
    logic [ADDR:0]    w_rbin_nxt;
    logic [ADDR:0]    w_wgray_r;
    logic [ADDR:0]    w_rgray_w;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en    = winc & ~full;
    assign w_rd_en    = rinc & ~empty;
    assign w_wbin_nxt = r_wbin + PTR_ONE;
    assign w_rbin_nxt = r_rbin + PTR_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbin  <= '0;
            r_wgray <= '0;
        end else if (w_wr_en) begin
            r_wbin  <= w_wbin_nxt;
            r_wgray <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rbin  <= '0;
            r_rgray <= '0;
        end else if (w_rd_en) begin
            r_rbin  <= w_rbin_nxt;
            r_rgray <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wbin[ADDR-1:0]] <= w_data;
        end
    end

`ifdef PTR_SYNC_EN
    logic [ADDR:0] r_wgray_q1;
    logic [ADDR:0] r_wgray_q2;
    logic [ADDR:0] r_rgray_q1;
    logic [ADDR:0] r_rgray_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wgray_q1 <= '0;
            r_wgray_q2 <= '0;
            r_rgray_q1 <= '0;
            r_rgray_q2 <= '0;
        end else begin
            r_wgray_q1 <= r_wgray;
            r_wgray_q2 <= r_wgray_q1;
            r_rgray_q1 <= r_rgray;
            r_rgray_q2 <= r_rgray_q1;
        end
    end

    assign w_wgray_r = r_wgray_q2;
    assign w_rgray_w = r_rgray_q2;
`else
    assign w_wgray_r = r_wgray;
    assign w_rgray_w = r_rgray;
`endif

    // Flags depend on registers only, so they stay pessimistic while a remote pointer lags.
    assign empty  = (r_rgray == w_wgray_r);
    assign full   = (r_wgray == (w_rgray_w ^ FULL_MASK));
    assign r_data = r_mem[r_rbin[ADDR-1:0]];

endmodule

// File: tb/tb_async_fifo_top.sv
// Scoreboard bench for async_fifo_top: count-based reference model for the flags,
// a data queue filled on accepted writes and drained by a read monitor.
module tb_async_fifo_top;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
`ifdef PTR_SYNC_EN
  localparam bit SYNC    = 1'b1;
  localparam int EMP_LAT = 3;
`else
  localparam bit SYNC    = 1'b0;
  localparam int EMP_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic [WIDTH-1:0] r_data;
  logic             full;
  logic             empty;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q [$];

  // Reference model: total accepted writes/reads, plus what the other side sees.
  int   wr_cnt, wr_d1, wr_d2, rd_cnt, rd_d1, rd_d2;
  logic m_full, m_empty;

  async_fifo_top #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .winc   (winc),
    .w_data (w_data),
    .rinc   (rinc),
    .r_data (r_data),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  assign m_empty = (rd_cnt == (SYNC ? wr_d2 : wr_cnt));
  assign m_full  = ((wr_cnt - (SYNC ? rd_d2 : rd_cnt)) == DEPTH);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= 0; wr_d1 <= 0; wr_d2 <= 0;
      rd_cnt <= 0; rd_d1 <= 0; rd_d2 <= 0;
    end else begin
      wr_d1 <= wr_cnt; wr_d2 <= wr_d1;
      rd_d1 <= rd_cnt; rd_d2 <= rd_d1;
      if (winc && !m_full)  wr_cnt <= wr_cnt + 1;
      if (rinc && !m_empty) rd_cnt <= rd_cnt + 1;
    end
  end

  // Scoreboard push: every write the model accepts.
  always @(posedge clk) begin
    if (rst && winc && !m_full) exp_q.push_back(w_data);
  end

  // Flag checker.
  always @(negedge clk) begin
    if (rst) begin
      check("full_flag", full, m_full);
      check("empty_flag", empty, m_empty);
    end
  end

  // Read monitor: the word presented on an accepted read must be the oldest written.
  always @(negedge clk) begin
    if (rst && rinc && !empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_underflow got=%0h expected=none at %0t", r_data, $time);
      end else begin
        check("r_data", r_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
    winc   = w;
    rinc   = r;
    w_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset with a write request held
    #1 rst = 1'b0;
    winc   = 1'b1;
    w_data = 8'h55;
    #10;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_rdata", r_data, 8'h00);
    rst  = 1'b1;
    winc = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_empty", empty, 1'b1);
    check("post_rst_full", full, 1'b0);
    check("post_rst_rdata", r_data, 8'h00);

    // Fill to full, then one ignored write
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b0, 8'(i));
    check("fill_full", full, 1'b1);
    cyc(1'b1, 1'b0, 8'd9);
    check("overfill_full", full, 1'b1);
    check("overfill_head", r_data, 8'd1);

    // Drain with two extra reads
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b1, 8'h00);
    check("drain_empty", empty, 1'b1);
    check("drain_queue", exp_q.size(), 0);

    // Simultaneous read/write at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 39; i++) begin
      cyc(1'b1, 1'b1, 8'(i));
      check("simul_full", full, 1'b0);
      check("simul_empty", empty, 1'b0);
    end
    check("simul_occ", exp_q.size(), 3);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
    check("simul_drained", empty, 1'b1);

    // Empty deassert latency
    cyc(1'b1, 1'b0, 8'h77);
    n = 1;
    while (empty && n < 10) begin
      cyc(1'b0, 1'b0, 8'h00);
      n++;
    end
    check("empty_latency", n, EMP_LAT);
    check("latency_head", r_data, 8'h77);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h00);

    // Interleaved write/read across pointer wraps
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 8'h00);
    check("wrap_empty", empty, 1'b1);
    check("wrap_queue", exp_q.size(), 0);

    // Random traffic: write-heavy then read-heavy
    for (int i = 0; i < 150; i++)
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
    for (int i = 0; i < 150; i++)
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 8'h00);
    check("random_queue", exp_q.size(), 0);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h50 + 8'(i));
    winc = 1'b0;
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_empty", empty, 1'b1);
    check("async_rst_full", full, 1'b0);
    check("async_rst_rdata", r_data, 8'h00);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 8'hA1);
    n = 0;
    while (empty && n < 10) begin
      cyc(1'b0, 1'b0, 8'h00);
      n++;
    end
    check("refill_ready", empty, 1'b0);
    check("refill_data", r_data, 8'hA1);
    cyc(1'b0, 1'b1, 8'h00);
    check("refill_drained", empty, 1'b1);

    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00);
    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
